// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 definitions for the SRAM slave and its burst address generator:
// burst type codes, response codes, and the write/read FSM state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrapLenOk(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi4_sram_slave_if
// AXI4 bus bundle between an interconnect master port and the SRAM slave.
// Ports: none (interface); modports:
//   slave  - the SRAM responder (drives ready on AW/AR/W, B and R channels)
//   master - the requester (drives AW/AR/W payloads, bready, rready)
// -----------------------------------------------------------------------------
interface axi4_sram_slave_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [7:0]            s_axi_awlen;
  logic [2:0]            s_axi_awsize;
  logic [1:0]            s_axi_awburst;

  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic                  s_axi_wlast;

  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [1:0]            s_axi_bresp;
  logic [ID_WIDTH-1:0]   s_axi_bid;

  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;

  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic                  s_axi_rlast;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    output s_axi_awready,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_wready,
    output s_axi_bvalid, s_axi_bresp, s_axi_bid,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    input  s_axi_awready,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp, s_axi_bid,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast,
    output s_axi_rready
  );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi4_burst_addr_gen
// Combinational next-beat address calculator for one AXI4 burst.
// Ports:
//   addr_i      - byte address of the current beat
//   len_i       - burst length minus one
//   size_i      - log2 of bytes per beat
//   burst_i     - burst type (FIXED / INCR / WRAP / reserved)
//   next_addr_o - byte address of the following beat
//   legal_o     - 1 when burst type, size and length are supported
// -----------------------------------------------------------------------------
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_SIZE   = 5
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  legal_o
);

  logic [ADDR_WIDTH-1:0] beatBytes;
  logic [ADDR_WIDTH-1:0] incrAddr;
  logic [ADDR_WIDTH-1:0] wrapBytes;
  logic [ADDR_WIDTH-1:0] wrapMask;

  // A WRAP burst stays inside an aligned container of (len+1)<<size bytes:
  // keep the container base from the current address and let only the
  // in-container offset bits follow the incremented address.
  always_comb begin
    beatBytes = ADDR_WIDTH'(1) << size_i;
    incrAddr  = addr_i + beatBytes;
    wrapBytes = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
    wrapMask  = wrapBytes - ADDR_WIDTH'(1);

    case (burst_e'(burst_i))
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incrAddr;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
      default:     next_addr_o = addr_i;
    endcase

    legal_o = (burst_i != BURST_RSVD) &&
              (int'(size_i) <= MAX_SIZE) &&
              ((burst_i != BURST_WRAP) || wrapLenOk(len_i));
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// axi4_sram_slave
// AXI4 responder backed by a register-array SRAM. One write burst and one
// read burst may be in flight at once on independent channels. Supports
// FIXED/INCR/WRAP bursts, byte strobes and narrow sizes; unsupported bursts
// and wlast mismatches answer SLVERR.
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset (outputs to 0, memory retained)
//   s_axi   - AXI4 slave bus (axi4_sram_slave_if.slave)
// -----------------------------------------------------------------------------
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input logic               aclk,
  input logic               aresetn,
  axi4_sram_slave_if.slave  s_axi
);

  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write channel state
  wr_state_e             wrState_q, wrState_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [ID_WIDTH-1:0]   wrId_q, wrId_d;
  logic [7:0]            wrLen_q, wrLen_d;
  logic [2:0]            wrSize_q, wrSize_d;
  logic [1:0]            wrBurst_q, wrBurst_d;
  logic [7:0]            wrBeat_q, wrBeat_d;
  logic                  wrErr_q, wrErr_d;
  logic                  wrOver_q, wrOver_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic                  memWe;

  // Read channel state
  rd_state_e             rdState_q, rdState_d;
  logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
  logic [7:0]            rdLen_q, rdLen_d;
  logic [2:0]            rdSize_q, rdSize_d;
  logic [1:0]            rdBurst_q, rdBurst_d;
  logic [7:0]            rdBeat_q, rdBeat_d;
  logic                  rdErr_q, rdErr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic                  rlast_q, rlast_d;

  // Address generator hookups
  logic [ADDR_WIDTH-1:0] wgAddr, wgNext, rgAddr, rgNext;
  logic [7:0]            wgLen, rgLen;
  logic [2:0]            wgSize, rgSize;
  logic [1:0]            wgBurst, rgBurst;
  logic                  wgLegal, rgLegal;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(LSB)) uWrAddrGen (
    .addr_i(wgAddr), .len_i(wgLen), .size_i(wgSize), .burst_i(wgBurst),
    .next_addr_o(wgNext), .legal_o(wgLegal)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(LSB)) uRdAddrGen (
    .addr_i(rgAddr), .len_i(rgLen), .size_i(rgSize), .burst_i(rgBurst),
    .next_addr_o(rgNext), .legal_o(rgLegal)
  );

  // Write FSM next state. While idle the generator looks at the AW request so
  // its legality can be judged at the handshake; afterwards it walks the
  // captured burst. Beats past awlen are absorbed without writing, and the
  // beat counter stops at awlen so a late wlast is detectable.
  always_comb begin
    wrState_d = wrState_q;
    wrAddr_d  = wrAddr_q;
    wrId_d    = wrId_q;
    wrLen_d   = wrLen_q;
    wrSize_d  = wrSize_q;
    wrBurst_d = wrBurst_q;
    wrBeat_d  = wrBeat_q;
    wrErr_d   = wrErr_q;
    wrOver_d  = wrOver_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    memWe     = 1'b0;
    wgAddr    = wrAddr_q;
    wgLen     = wrLen_q;
    wgSize    = wrSize_q;
    wgBurst   = wrBurst_q;

    if (wrState_q == W_IDLE) begin
      wgAddr  = s_axi.s_axi_awaddr;
      wgLen   = s_axi.s_axi_awlen;
      wgSize  = s_axi.s_axi_awsize;
      wgBurst = s_axi.s_axi_awburst;
    end

    case (wrState_q)
      W_IDLE: begin
        if (s_axi.s_axi_awvalid && awready_q) begin
          wrState_d = W_DATA;
          wrAddr_d  = s_axi.s_axi_awaddr;
          wrId_d    = s_axi.s_axi_awid;
          wrLen_d   = s_axi.s_axi_awlen;
          wrSize_d  = s_axi.s_axi_awsize;
          wrBurst_d = s_axi.s_axi_awburst;
          wrBeat_d  = 8'd0;
          wrErr_d   = !wgLegal;
          wrOver_d  = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi.s_axi_wvalid && wready_q) begin
          memWe = !wrErr_q && !wrOver_q;
          if (!wrOver_q) begin
            wrAddr_d = wgNext;
          end
          if (wrBeat_q == wrLen_q) begin
            if (!s_axi.s_axi_wlast) begin
              wrOver_d = 1'b1;
            end
          end else begin
            wrBeat_d = wrBeat_q + 8'd1;
          end
          if (s_axi.s_axi_wlast) begin
            wrState_d = W_RESP;
            bid_d     = wrId_q;
            bresp_d   = (wrErr_q || wrOver_q || (wrBeat_q != wrLen_q)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.s_axi_bready && bvalid_q) begin
          wrState_d = W_IDLE;
        end
      end
      default: wrState_d = W_IDLE;
    endcase

    awready_d = (wrState_d == W_IDLE);
    wready_d  = (wrState_d == W_DATA);
    bvalid_d  = (wrState_d == W_RESP);
  end

  // Write FSM registers; outputs are registered copies of the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrState_q <= W_IDLE;
      wrAddr_q  <= '0;
      wrId_q    <= '0;
      wrLen_q   <= '0;
      wrSize_q  <= '0;
      wrBurst_q <= '0;
      wrBeat_q  <= '0;
      wrErr_q   <= 1'b0;
      wrOver_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      wrState_q <= wrState_d;
      wrAddr_q  <= wrAddr_d;
      wrId_q    <= wrId_d;
      wrLen_q   <= wrLen_d;
      wrSize_q  <= wrSize_d;
      wrBurst_q <= wrBurst_d;
      wrBeat_q  <= wrBeat_d;
      wrErr_q   <= wrErr_d;
      wrOver_q  <= wrOver_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  // SRAM byte-lane writes. Not reset so contents survive a bus reset.
  always_ff @(posedge aclk) begin
    if (memWe) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.s_axi_wstrb[b]) begin
          mem[wrAddr_q[LSB +: IDX_W]][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM next state. Each accepted beat preloads the following word into
  // rdata so the channel streams without bubbles; the array is read before the
  // write port updates, so a same-edge collision returns the old word.
  always_comb begin
    rdState_d = rdState_q;
    rdAddr_d  = rdAddr_q;
    rdLen_d   = rdLen_q;
    rdSize_d  = rdSize_q;
    rdBurst_d = rdBurst_q;
    rdBeat_d  = rdBeat_q;
    rdErr_d   = rdErr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;
    rgAddr    = rdAddr_q;
    rgLen     = rdLen_q;
    rgSize    = rdSize_q;
    rgBurst   = rdBurst_q;

    if (rdState_q == R_IDLE) begin
      rgAddr  = s_axi.s_axi_araddr;
      rgLen   = s_axi.s_axi_arlen;
      rgSize  = s_axi.s_axi_arsize;
      rgBurst = s_axi.s_axi_arburst;
    end

    case (rdState_q)
      R_IDLE: begin
        if (s_axi.s_axi_arvalid && arready_q) begin
          rdState_d = R_DATA;
          rdAddr_d  = s_axi.s_axi_araddr;
          rdLen_d   = s_axi.s_axi_arlen;
          rdSize_d  = s_axi.s_axi_arsize;
          rdBurst_d = s_axi.s_axi_arburst;
          rdBeat_d  = 8'd0;
          rdErr_d   = !rgLegal;
          rdata_d   = rgLegal ? mem[s_axi.s_axi_araddr[LSB +: IDX_W]] : '0;
          rresp_d   = rgLegal ? RESP_OKAY : RESP_SLVERR;
          rid_d     = s_axi.s_axi_arid;
          rlast_d   = (s_axi.s_axi_arlen == 8'd0);
        end
      end
      R_DATA: begin
        if (s_axi.s_axi_rready && rvalid_q) begin
          if (rlast_q) begin
            rdState_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            rdAddr_d = rgNext;
            rdBeat_d = rdBeat_q + 8'd1;
            rdata_d  = rdErr_q ? '0 : mem[rgNext[LSB +: IDX_W]];
            rlast_d  = ((rdBeat_q + 8'd1) == rdLen_q);
          end
        end
      end
      default: rdState_d = R_IDLE;
    endcase

    arready_d = (rdState_d == R_IDLE);
    rvalid_d  = (rdState_d == R_DATA);
  end

  // Read FSM registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdState_q <= R_IDLE;
      rdAddr_q  <= '0;
      rdLen_q   <= '0;
      rdSize_q  <= '0;
      rdBurst_q <= '0;
      rdBeat_q  <= '0;
      rdErr_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
    end else begin
      rdState_q <= rdState_d;
      rdAddr_q  <= rdAddr_d;
      rdLen_q   <= rdLen_d;
      rdSize_q  <= rdSize_d;
      rdBurst_q <= rdBurst_d;
      rdBeat_q  <= rdBeat_d;
      rdErr_q   <= rdErr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_bid     = bid_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign s_axi.s_axi_rid     = rid_q;
  assign s_axi.s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_sram_slave
// Directed self-checking bench for axi4_sram_slave with default parameters
// (256-bit data, 32-byte words, 1024 words).
// -----------------------------------------------------------------------------
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi4_sram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi4_sram_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(1024)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axi(bus)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] wData [32];
  logic [SW-1:0] wStrb [32];
  logic [DW-1:0] rData [32];
  logic [1:0]    rResp [32];
  logic          rLast [32];
  logic [IW-1:0] rId   [32];
  int            rCount;
  int            stallErr;
  int            bStallOk;

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {SW{b}};
  endfunction

  task automatic initBus();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0; bus.s_axi_awid = '0;
    bus.s_axi_awlen = '0; bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arid = '0;
    bus.s_axi_arlen = '0; bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
    bus.s_axi_rready = 1'b0;
  endtask

  // Full write transaction: AW, nBeats W beats (wlast on the last one), then
  // B after holding bready low for bDelay cycles.
  task automatic doWrite(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id, input int nBeats,
                         input int bDelay, output logic [1:0] resp, output logic [IW-1:0] bidOut);
    int cyc;
    resp = 2'bxx;
    bidOut = 'x;
    bStallOk = 0;
    @(negedge aclk);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
    bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awid = id;
    cyc = 0;
    while (bus.s_axi_awready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
    if (cyc >= 50) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL aw_timeout: awready %b required 1", bus.s_axi_awready);
      bus.s_axi_awvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = wData[i]; bus.s_axi_wstrb = wStrb[i];
      bus.s_axi_wlast = (i == nBeats - 1);
      cyc = 0;
      while (bus.s_axi_wready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
      if (cyc >= 50) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL w_timeout: wready %b required 1 at beat %0d", bus.s_axi_wready, i);
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        return;
      end
      @(negedge aclk);
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast = 1'b0;
    cyc = 0;
    while (bus.s_axi_bvalid !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
    if (cyc >= 50) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL b_timeout: bvalid %b required 1", bus.s_axi_bvalid);
      return;
    end
    for (int k = 0; k < bDelay; k++) begin
      if (bus.s_axi_bvalid === 1'b1 && bus.s_axi_awready === 1'b0) bStallOk++;
      @(negedge aclk);
    end
    resp = bus.s_axi_bresp;
    bidOut = bus.s_axi_bid;
    bus.s_axi_bready = 1'b1;
    @(negedge aclk);
    bus.s_axi_bready = 1'b0;
  endtask

  // Full read transaction; rready either held high or toggled 1,0,1,0.
  // Beats are recorded in rData/rResp/rLast/rId, stall stability in stallErr,
  // and rCount also picks up any beats offered after rlast.
  task automatic doRead(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [IW-1:0] id, input bit toggle);
    int cyc;
    bit done;
    bit haveHeld;
    logic [DW-1:0] heldData;
    logic heldLast;
    rCount = 0;
    stallErr = 0;
    @(negedge aclk);
    bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
    bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arid = id;
    cyc = 0;
    while (bus.s_axi_arready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
    if (cyc >= 50) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL ar_timeout: arready %b required 1", bus.s_axi_arready);
      bus.s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    bus.s_axi_arvalid = 1'b0;
    cyc = 0;
    done = 1'b0;
    haveHeld = 1'b0;
    heldData = '0;
    heldLast = 1'b0;
    while (!done && cyc < 200) begin
      bus.s_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (haveHeld && (bus.s_axi_rdata !== heldData || bus.s_axi_rlast !== heldLast)) stallErr++;
      haveHeld = 1'b0;
      if (bus.s_axi_rvalid === 1'b1) begin
        if (bus.s_axi_rready) begin
          if (rCount < 32) begin
            rData[rCount] = bus.s_axi_rdata; rResp[rCount] = bus.s_axi_rresp;
            rLast[rCount] = bus.s_axi_rlast; rId[rCount] = bus.s_axi_rid;
          end
          rCount++;
          if (bus.s_axi_rlast === 1'b1) done = 1'b1;
        end else begin
          haveHeld = 1'b1;
          heldData = bus.s_axi_rdata;
          heldLast = bus.s_axi_rlast;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    if (!done) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL r_timeout: %0d beats seen, no rlast handshake", rCount);
    end
    bus.s_axi_rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.s_axi_rvalid === 1'b1) rCount++;
      @(negedge aclk);
    end
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    testsRun++;
    if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: aw/ar/w ready, bvalid, rvalid = %b required 00000",
               {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid});
    end
    testsRun++;
    if (bus.s_axi_rdata !== '0 || bus.s_axi_bresp !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: rdata %h bresp %b required 0", bus.s_axi_rdata, bus.s_axi_bresp);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    testsRun++;
    if (bus.s_axi_awready !== 1'b1 || bus.s_axi_arready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_ready: awready %b arready %b required 1 1",
               bus.s_axi_awready, bus.s_axi_arready);
    end
  endtask

  task automatic test_incr_round_trip();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    for (int i = 0; i < 4; i++) begin wData[i] = rep(8'hA0 + 8'(i)); wStrb[i] = '1; end
    doWrite(32'h1000_0040, 8'd3, 3'd5, BURST_INCR, 4'd5, 4, 0, resp, bidv);
    testsRun++;
    if (resp !== RESP_OKAY) begin testsFailed++; $display("[TB] FAIL incr_bresp: got %b required 00", resp); end
    testsRun++;
    if (bidv !== 4'd5) begin testsFailed++; $display("[TB] FAIL incr_bid: got %0d required 5", bidv); end
    doRead(32'h1000_0040, 8'd3, 3'd5, BURST_INCR, 4'd5, 1'b0);
    testsRun++;
    if (rCount !== 4) begin testsFailed++; $display("[TB] FAIL incr_beats: got %0d required 4", rCount); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (rData[i] !== rep(8'hA0 + 8'(i)) || rLast[i] !== (i == 3) || rId[i] !== 4'd5 || rResp[i] !== RESP_OKAY) begin
        testsFailed++;
        $display("[TB] FAIL incr_read_beat%0d: data %h last %b id %0d resp %b required byte %h last %b id 5 resp 00",
                 i, rData[i], rLast[i], rId[i], rResp[i], 8'hA0 + 8'(i), (i == 3));
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    logic [7:0] expByte [4];
    expByte[0] = 8'h03; expByte[1] = 8'h00; expByte[2] = 8'h01; expByte[3] = 8'h02;
    for (int i = 0; i < 4; i++) begin wData[i] = rep(8'(i)); wStrb[i] = '1; end
    doWrite(32'h1000_0000, 8'd3, 3'd5, BURST_INCR, 4'd1, 4, 0, resp, bidv);
    doRead(32'h1000_0060, 8'd3, 3'd5, BURST_WRAP, 4'd2, 1'b0);
    testsRun++;
    if (rCount !== 4) begin testsFailed++; $display("[TB] FAIL wrap_beats: got %0d required 4", rCount); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (rData[i] !== rep(expByte[i]) || rResp[i] !== RESP_OKAY) begin
        testsFailed++;
        $display("[TB] FAIL wrap_beat%0d: data %h resp %b required byte %h resp 00", i, rData[i], rResp[i], expByte[i]);
      end
    end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    logic [DW-1:0] expWord;
    wData[0] = '0; wStrb[0] = '1;
    doWrite(32'h0000_0000, 8'd0, 3'd5, BURST_INCR, 4'd0, 1, 0, resp, bidv);
    wData[0] = rep(8'hFF); wStrb[0] = 32'h0000_000F;
    doWrite(32'h0000_0000, 8'd0, 3'd5, BURST_INCR, 4'd0, 1, 0, resp, bidv);
    doRead(32'h0000_0000, 8'd0, 3'd5, BURST_INCR, 4'd0, 1'b0);
    expWord = {{28{8'h00}}, {4{8'hFF}}};
    testsRun++;
    if (rData[0] !== expWord) begin
      testsFailed++;
      $display("[TB] FAIL partial_strobe: got %h required %h", rData[0], expWord);
    end
  endtask

  task automatic test_narrow();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    logic [DW-1:0] expWord;
    wData[0] = rep(8'h11); wStrb[0] = 32'h0000_000F;
    wData[1] = rep(8'h22); wStrb[1] = 32'h0000_00F0;
    doWrite(32'h1000_0020, 8'd1, 3'd2, BURST_INCR, 4'd3, 2, 0, resp, bidv);
    testsRun++;
    if (resp !== RESP_OKAY) begin testsFailed++; $display("[TB] FAIL narrow_bresp: got %b required 00", resp); end
    doRead(32'h1000_0020, 8'd0, 3'd5, BURST_INCR, 4'd3, 1'b0);
    expWord = {{24{8'h01}}, {4{8'h22}}, {4{8'h11}}};
    testsRun++;
    if (rData[0] !== expWord) begin
      testsFailed++;
      $display("[TB] FAIL narrow_word: got %h required %h", rData[0], expWord);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    for (int i = 0; i < 8; i++) begin wData[i] = rep(8'h40 + 8'(i)); wStrb[i] = '1; end
    doWrite(32'h0000_0100, 8'd7, 3'd5, BURST_INCR, 4'd7, 8, 5, resp, bidv);
    testsRun++;
    if (bStallOk !== 5) begin
      testsFailed++;
      $display("[TB] FAIL b_stall_hold: held cycles %0d required 5", bStallOk);
    end
    testsRun++;
    if (resp !== RESP_OKAY || bidv !== 4'd7) begin
      testsFailed++;
      $display("[TB] FAIL b_stall_resp: resp %b bid %0d required 00 7", resp, bidv);
    end
    testsRun++;
    if (bus.s_axi_awready !== 1'b1 || bus.s_axi_bvalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b_after_handshake: awready %b bvalid %b required 1 0", bus.s_axi_awready, bus.s_axi_bvalid);
    end
    doRead(32'h0000_0100, 8'd7, 3'd5, BURST_INCR, 4'd8, 1'b1);
    testsRun++;
    if (rCount !== 8) begin testsFailed++; $display("[TB] FAIL bp_beats: got %0d required 8", rCount); end
    testsRun++;
    if (stallErr !== 0) begin testsFailed++; $display("[TB] FAIL bp_stable: unstable stalls %0d required 0", stallErr); end
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (rData[i] !== rep(8'h40 + 8'(i)) || rLast[i] !== (i == 7)) begin
        testsFailed++;
        $display("[TB] FAIL bp_beat%0d: data %h last %b required byte %h last %b",
                 i, rData[i], rLast[i], 8'h40 + 8'(i), (i == 7));
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [IW-1:0] bidv;
    wData[0] = rep(8'h5A); wStrb[0] = '1;
    doWrite(32'h0000_0280, 8'd0, 3'd5, BURST_INCR, 4'd0, 1, 0, resp, bidv);
    wData[0] = rep(8'hC3); wStrb[0] = '1;
    doWrite(32'h0000_0280, 8'd0, 3'd5, 2'b11, 4'd9, 1, 0, resp, bidv);
    testsRun++;
    if (resp !== RESP_SLVERR || bidv !== 4'd9) begin
      testsFailed++;
      $display("[TB] FAIL err_burst_bresp: resp %b bid %0d required 10 9", resp, bidv);
    end
    doRead(32'h0000_0280, 8'd0, 3'd5, BURST_INCR, 4'd0, 1'b0);
    testsRun++;
    if (rData[0] !== rep(8'h5A)) begin
      testsFailed++;
      $display("[TB] FAIL err_burst_mem: got %h required %h", rData[0], rep(8'h5A));
    end
    for (int i = 0; i < 2; i++) begin wData[i] = rep(8'h77); wStrb[i] = '1; end
    doWrite(32'h0000_02A0, 8'd3, 3'd5, BURST_INCR, 4'd2, 2, 0, resp, bidv);
    testsRun++;
    if (resp !== RESP_SLVERR) begin testsFailed++; $display("[TB] FAIL early_wlast: got %b required 10", resp); end
    for (int i = 0; i < 3; i++) begin wData[i] = rep(8'h66); wStrb[i] = '1; end
    doWrite(32'h0000_02C0, 8'd0, 3'd5, BURST_INCR, 4'd2, 3, 0, resp, bidv);
    testsRun++;
    if (resp !== RESP_SLVERR) begin testsFailed++; $display("[TB] FAIL late_wlast: got %b required 10", resp); end
    doRead(32'h0000_0280, 8'd1, 3'd5, 2'b11, 4'd4, 1'b0);
    testsRun++;
    if (rCount !== 2 || rData[0] !== '0 || rData[1] !== '0 || rResp[0] !== RESP_SLVERR ||
        rResp[1] !== RESP_SLVERR || rLast[1] !== 1'b1 || rId[1] !== 4'd4) begin
      testsFailed++;
      $display("[TB] FAIL err_read_burst: beats %0d resp %b %b last %b id %0d required 2 10 10 1 4",
               rCount, rResp[0], rResp[1], rLast[1], rId[1]);
    end
    doRead(32'h0000_0280, 8'd0, 3'd6, BURST_INCR, 4'd4, 1'b0);
    testsRun++;
    if (rCount !== 1 || rData[0] !== '0 || rResp[0] !== RESP_SLVERR) begin
      testsFailed++;
      $display("[TB] FAIL err_read_size: beats %0d data %h resp %b required 1 0 10", rCount, rData[0], rResp[0]);
    end
    doRead(32'h0000_0280, 8'd2, 3'd5, BURST_WRAP, 4'd4, 1'b0);
    testsRun++;
    if (rCount !== 3 || rResp[0] !== RESP_SLVERR || rResp[2] !== RESP_SLVERR || rData[2] !== '0) begin
      testsFailed++;
      $display("[TB] FAIL err_read_wraplen: beats %0d resp %b %b required 3 10 10", rCount, rResp[0], rResp[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    @(negedge aclk);
    bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = 32'h0000_0100; bus.s_axi_arlen = 8'd3;
    bus.s_axi_arsize = 3'd5; bus.s_axi_arburst = BURST_INCR; bus.s_axi_arid = 4'd6;
    cyc = 0;
    while (bus.s_axi_arready !== 1'b1 && cyc < 50) begin @(negedge aclk); cyc++; end
    @(negedge aclk);
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    bus.s_axi_rready = 1'b0;
    testsRun++;
    if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== rep(8'h42)) begin
      testsFailed++;
      $display("[TB] FAIL midrst_beat2: rvalid %b data %h required 1 %h", bus.s_axi_rvalid, bus.s_axi_rdata, rep(8'h42));
    end
    aresetn = 1'b0;
    #1;
    testsRun++;
    if (bus.s_axi_rvalid !== 1'b0 || bus.s_axi_arready !== 1'b0 || bus.s_axi_rdata !== '0 || bus.s_axi_rlast !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_immediate: rvalid %b arready %b rlast %b required 0 0 0",
               bus.s_axi_rvalid, bus.s_axi_arready, bus.s_axi_rlast);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    testsRun++;
    if (bus.s_axi_arready !== 1'b1 || bus.s_axi_rvalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midrst_release: arready %b rvalid %b required 1 0", bus.s_axi_arready, bus.s_axi_rvalid);
    end
    doRead(32'h0000_0120, 8'd0, 3'd5, BURST_INCR, 4'd6, 1'b0);
    testsRun++;
    if (rData[0] !== rep(8'h41)) begin
      testsFailed++;
      $display("[TB] FAIL midrst_retained: got %h required %h", rData[0], rep(8'h41));
    end
  endtask

  initial begin
    initBus();
    test_reset();
    test_incr_round_trip();
    test_wrap_read();
    test_partial_strobe();
    test_narrow();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

AXI4 memory-mapped responder backed by on-chip SRAM (register array), serving one downstream slave port of `axi4_interconnect`. It accepts one write burst and one read burst at a time on independent channels. It supports FIXED, INCR and WRAP bursts, byte strobes and narrow sizes, and returns AXI4 B/R responses carrying the request ID. It is the default scratchpad endpoint for KAN coefficient and TDA buffer storage.

## Interface
- DATA_WIDTH, 256, data bus width in bits
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- aclk  in  1  clock; one clock domain
- aresetn  in  1  asynchronous, active-low reset
- s_axi_awvalid / s_axi_arvalid  in  1  address valid
- s_axi_awready / s_axi_arready  out  1  address ready
- s_axi_awaddr / s_axi_araddr  in  ADDR_WIDTH  byte start address
- s_axi_awid / s_axi_arid  in  ID_WIDTH  transaction ID
- s_axi_awlen / s_axi_arlen  in  8  beats minus one
- s_axi_awsize / s_axi_arsize  in  3  log2 of bytes per beat
- s_axi_awburst / s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_wvalid  in  1  / s_axi_wready  out  1  write data handshake
- s_axi_wdata  in  DATA_WIDTH  / s_axi_wstrb  in  STRB_WIDTH  / s_axi_wlast  in  1
- s_axi_bvalid  out  1  / s_axi_bready  in  1  write response handshake
- s_axi_bresp  out  2  / s_axi_bid  out  ID_WIDTH
- s_axi_rvalid  out  1  / s_axi_rready  in  1  read data handshake
- s_axi_rdata  out  DATA_WIDTH  / s_axi_rresp  out  2  / s_axi_rid  out  ID_WIDTH  / s_axi_rlast  out  1

## Operation
- **Output registers and reset.** All outputs are registered and reset to 0. Memory contents are not reset. The word index is addr[LSB +: log2(MEM_DEPTH)], where LSB = log2(STRB_WIDTH). Upper address bits are ignored, so the memory aliases.
- **Write FSM:** W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE.
  - The AW handshake captures addr, id, len, size and burst.
  - Each W handshake writes the bytes whose wstrb bit is 1 into the current word, then advances the address.
  - A W handshake with wlast=1 moves the FSM to W_RESP. B is held until bready=1.
- **Read FSM:** R_IDLE (arready=1) -> R_DATA (rvalid=1) -> R_IDLE.
  - The AR handshake loads beat 0 into rdata.
  - Each R handshake on a non-last beat loads the next beat, with no bubble.
  - rlast=1 on beat arlen. The R handshake on that beat moves the FSM to R_IDLE.
- **Address advance.**
  - FIXED: no change.
  - INCR: addr + (1<<size).
  - WRAP: wraps within a container of (len+1)<<size bytes, aligned to that size.
  - Narrow beats land in the same word until they cross a word boundary. Reads always return the full word.
- **Errors (SLVERR = 2'b10).** All of the following produce SLVERR:
  - burst 2'b11;
  - size > LSB;
  - WRAP with len not in {1,3,7,15}.

  On these errors:
  - Write: data beats are accepted and dropped until wlast, then bresp=SLVERR.
  - Read: arlen+1 beats are returned with rdata=0 and rresp=SLVERR on every beat.
- **wlast mismatch.**
  - Early wlast (before beat awlen): the burst ends there, and bresp=SLVERR.
  - wlast=0 at beat awlen: further beats are accepted and not written until wlast, then bresp=SLVERR.
- **Response values.** bid=awid and rid=arid, captured at the address handshake. All other responses are OKAY (2'b00).
- **Same-word collision.** If a write and a read load of the same word occur on the same edge, the read gets the old data.

## Timing
- awready and arready rise on the first edge after aresetn deasserts.
- AW handshake at edge N: awready=0 and wready=1 from N+1.
- wlast handshake at edge M: wready=0 and bvalid=1 from M+1.
- B handshake at edge K: awready=1 from K+1.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1. Throughput is one beat per cycle while rready=1.
- While rvalid=1 and rready=0, rdata, rresp, rid and rlast are held stable.
- Last R handshake at edge K: arready=1 from K+1.
- Read and write channels are fully independent and progress on the same cycles.
- Reset mid-burst: every output goes to 0 immediately, both FSMs return to IDLE, and beats already written are retained.

## Structure
- Shared package `axi4_pkg` holds:
  - burst codes (FIXED, INCR, WRAP);
  - resp codes (OKAY, EXOKAY, SLVERR, DECERR);
  - the FSM state encodings.
- Sub-module `axi4_burst_addr_gen` is combinational. It takes addr, len, size and burst and produces next_addr and a legal flag. It is instantiated once for writes and once for reads.

## Test plan
All scenarios use the defaults (32-byte words).
- **INCR round trip.** INCR write, awaddr 0x1000_0040, len 3, size 5, id 5, data 0xA0..A3 (replicated), wstrb all ones; then an INCR read of the same burst.
  - Write: bresp 00, bid 5.
  - Read: 4 beats equal A0..A3, rlast only on beat 3, rid 5.
- **WRAP read.** Words 0..3 preloaded with 0x00..0x03; arburst WRAP, araddr 0x1000_0060, len 3, size 5 -> beats 0x03, 0x00, 0x01, 0x02.
- **Partial strobe.** Word 0 cleared; write 0xFF.. with wstrb 0x0000_000F -> readback has bytes 0-3 = FF and the rest 00.
- **Backpressure.**
  - 8-beat INCR read with rready toggling 1,0,1,0: exactly 8 handshakes, rdata stable on every stall.
  - bready held 0 for 5 cycles: bvalid held and awready stays 0 until the B handshake.
- **Errors.**
  - awburst 2'b11 -> bresp 2'b10 and memory unchanged.
  - awlen 3 with wlast on beat 1 -> bresp 2'b10.
- **Reset mid-burst.** aresetn pulled low during beat 2 of a 4-beat read -> rvalid 0 immediately, arready 1 one edge after release, previously written data still readable.
